// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow clock-like input in clk_i cycles.
// Optional running min/max of valid periods when CLK_PERIOD_METER_MINMAX_EN is defined.
module clk_period_meter #(
   parameter int COUNT_SIZE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  meas_clk_i,
   input  logic                  ready_i,
`ifdef CLK_PERIOD_METER_MINMAX_EN
   input  logic                  minmax_clr_i,
   output logic [COUNT_SIZE-1:0] period_min_o,
   output logic [COUNT_SIZE-1:0] period_max_o,
`endif
   output logic [COUNT_SIZE-1:0] period_o,
   output logic [COUNT_SIZE-1:0] high_o,
   output logic                  overflow_o,
   output logic                  valid_o,
   output logic                  busy_o
);
   typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} state_t;
   localparam logic [COUNT_SIZE-1:0] MAX = '1;
   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic                    prev_q, prev_d;
   logic [COUNT_SIZE-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [COUNT_SIZE-1:0]   period_q, period_d, high_q, high_d;
   logic                    ovf_q, ovf_d, fell_q, fell_d;
   logic                    s, rise, fall, last;
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], meas_clk_i};
      s        = sync_q[SYNC_STAGES-1];
      prev_d   = s;
      rise     = s & ~prev_q;
      fall     = ~s & prev_q;
      cnt_inc  = (cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
      last     = cnt_inc == MAX;
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      high_d   = high_q;
      ovf_d    = ovf_q;
      fell_d   = fell_q;
      if (!en_i) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
               cnt_d   = '0;
            end
            ARM: begin
               if (rise) begin
                  state_d = MEAS;
                  cnt_d   = COUNT_SIZE'(1);
                  fell_d  = 1'b0;
               end else if (last) begin
                  state_d  = HOLD;
                  period_d = MAX;
                  high_d   = '0;
                  ovf_d    = 1'b1;
               end else cnt_d = cnt_inc;
            end
            MEAS: begin
               cnt_d = cnt_inc;
               if (fall) begin
                  high_d = cnt_q;
                  fell_d = 1'b1;
               end
               // a period that would reach all-ones is reported as overflow
               if (rise) begin
                  state_d  = HOLD;
                  period_d = cnt_q;
                  ovf_d    = 1'b0;
               end else if (last) begin
                  state_d  = HOLD;
                  period_d = MAX;
                  ovf_d    = 1'b1;
                  if (!fall && !fell_q) high_d = MAX;
               end
            end
            default: if (ready_i) begin
               state_d = ARM;
               cnt_d   = '0;
            end
         endcase
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         high_q   <= '0;
         ovf_q    <= 1'b0;
         fell_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         ovf_q    <= ovf_d;
         fell_q   <= fell_d;
      end
   end
   assign period_o   = period_q;
   assign high_o     = high_q;
   assign overflow_o = ovf_q;
   assign valid_o    = state_q == HOLD;
   assign busy_o     = state_q != IDLE;
`ifdef CLK_PERIOD_METER_MINMAX_EN
   logic [COUNT_SIZE-1:0] min_q, min_d, max_q, max_d;
   logic                  upd;
   always_comb begin
      upd   = (state_q != HOLD) && (state_d == HOLD) && !ovf_d;
      min_d = minmax_clr_i ? MAX : (upd && period_d < min_q) ? period_d : min_q;
      max_d = minmax_clr_i ? '0 : (upd && period_d > max_q) ? period_d : max_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_q <= MAX;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end
   assign period_min_o = min_q;
   assign period_max_o = max_q;
`endif
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized and directed checks of clk_period_meter against a
// time-based reference model that derives each result from the sampled input history.
module tb_clk_period_meter;
   localparam int CS   = 4;
   localparam int SS   = 2;
   localparam int MAXV = (1 << CS) - 1;
   localparam int NH   = 60000;
   logic          clk = 0, rst = 1, en = 1, meas = 0, ready = 1;
   logic [CS-1:0] period, high;
   logic          ovf, valid, busy;
`ifdef CLK_PERIOD_METER_MINMAX_EN
   logic          clr = 0;
   logic [CS-1:0] pmin, pmax;
   int            mn = MAXV, mx = 0;
`endif
   always #5 clk = ~clk;
   clk_period_meter #(.COUNT_SIZE(CS), .SYNC_STAGES(SS)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .meas_clk_i(meas), .ready_i(ready),
`ifdef CLK_PERIOD_METER_MINMAX_EN
      .minmax_clr_i(clr), .period_min_o(pmin), .period_max_o(pmax),
`endif
      .period_o(period), .high_o(high), .overflow_o(ovf), .valid_o(valid), .busy_o(busy)
   );
   int compared = 0, mismatched = 0;
   int n = 0;
   bit mh [0:NH-1];
   int mm = 0, a = 0, e_p = 0, e_h = 0, e_o = 0;
   bit rst_e = 1;
   int gmode = 0, gdiv = 2, ghi = 1, ph = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, n);
      end
   endtask
   function automatic bit sv(input int e);
      return (e - SS >= 0 && e - SS < NH) ? mh[e-SS] : 1'b0;
   endfunction
   function automatic bit rise(input int e); return sv(e) && !sv(e - 1); endfunction
   function automatic bit fall(input int e); return !sv(e) && sv(e - 1); endfunction
   // result of a measurement armed at edge a, if it completes exactly at edge now
   function automatic bit resolve(input int a0, input int now, output int p, output int h, output int o);
      int t = -1, hk = -1;
      p = 0; h = 0; o = 0;
      for (int e = a0; e <= now; e++) begin
         if (t < 0) begin
            if (rise(e)) t = e;
            else if (e - a0 == MAXV - 1) begin p = MAXV; h = 0; o = 1; return e == now; end
         end else begin
            if (rise(e)) begin p = e - t; h = hk; o = 0; return e == now; end
            if (fall(e)) hk = e - t;
            if (e - t == MAXV - 1) begin p = MAXV; h = (hk < 0) ? MAXV : hk; o = 1; return e == now; end
         end
      end
      return 1'b0;
   endfunction
   always @(negedge clk) begin
      if (gmode == 0) begin
         ph   = (ph + 1 >= gdiv) ? 0 : ph + 1;
         meas = ph < ghi;
      end else if (gmode == 1) meas = 0;
      else if (gmode == 2) meas = 1;
      else begin
         meas = 1;
         #3 meas = 0;
      end
   end
   always @(posedge clk) begin
      int rp, rh, ro;
      if (n < NH) mh[n] = rst ? 1'b0 : meas;
      rst_e = rst;
      if (rst || !en) mm = 0;
      else if (mm == 0) begin mm = 1; a = n + 1; end
      else if (mm == 1) begin
         if (resolve(a, n, rp, rh, ro)) begin
            mm = 2; e_p = rp; e_h = rh; e_o = ro;
`ifdef CLK_PERIOD_METER_MINMAX_EN
            if (ro == 0) begin
               if (rp < mn) mn = rp;
               if (rp > mx) mx = rp;
            end
`endif
         end
      end else if (ready) begin mm = 1; a = n + 1; end
`ifdef CLK_PERIOD_METER_MINMAX_EN
      if (rst || clr) begin mn = MAXV; mx = 0; end
`endif
      n++;
   end
   initial forever begin
      @(negedge clk);
      if (n > 0) begin
         chk("busy", busy, mm != 0);
         chk("valid", valid, mm == 2);
         if (mm == 2) begin
            chk("period", period, e_p);
            chk("high", high, e_h);
            chk("overflow", ovf, e_o);
         end
         if (rst_e) begin
            chk("rst_period", period, 0);
            chk("rst_high", high, 0);
            chk("rst_overflow", ovf, 0);
         end
`ifdef CLK_PERIOD_METER_MINMAX_EN
         chk("period_min", pmin, mn);
         chk("period_max", pmax, mx);
`endif
      end
   end
   task automatic wait_valid();
      for (int i = 0; i < 200 && !valid; i++) @(negedge clk);
      if (!valid) chk("valid_timeout", valid, 1);
   endtask
   task automatic skip(input int k);
      repeat (k) begin
         wait_valid();
         @(negedge clk);
      end
   endtask
   task automatic res(input string name, input int p, input int h, input int o);
      wait_valid();
      chk({name, "_period"}, period, p);
      chk({name, "_high"}, high, h);
      chk({name, "_overflow"}, ovf, o);
      chk({name, "_model"}, {e_p[9:0], e_h[9:0], e_o[9:0]}, {p[9:0], h[9:0], o[9:0]});
      @(negedge clk);
   endtask
   task automatic set_div(input int d, input int h);
      gmode = 0; gdiv = d; ghi = h;
   endtask
   initial begin
      set_div(2, 1);
      repeat (5) @(negedge clk);
      chk("rst_busy", busy, 0);
      rst = 0;
      @(negedge clk);
      chk("arm_after_rst", busy, 1);
      set_div(4, 2); skip(2); res("div4a", 4, 2, 0); res("div4b", 4, 2, 0);
      set_div(5, 2); skip(2); res("div5", 5, 2, 0);
      set_div(9, 4); skip(2); res("div9", 9, 4, 0);
      set_div(6, 3); skip(2);
      ready = 0;
      wait_valid();
      repeat (20) @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_period", period, 6);
      chk("hold_high", high, 3);
      ready = 1;
      @(negedge clk);
      res("div6_next", 6, 3, 0);
      set_div(14, 7); skip(2); res("div14", 14, 7, 0);
      set_div(15, 7); skip(2); res("div15", MAXV, 7, 1);
      gmode = 1; skip(2); res("stuck0", MAXV, 0, 1);
      gmode = 2; skip(2); res("stuck1", MAXV, 0, 1);
      gmode = 3; skip(2); res("bypass", MAXV, 0, 1);
      set_div(8, 4); skip(2);
      repeat (10) @(negedge clk);
      en = 0;
      @(negedge clk);
      chk("en_meas_busy", busy, 0);
      chk("en_meas_valid", valid, 0);
      en = 1;
      res("reen_meas", 8, 4, 0);
      ready = 0;
      wait_valid();
      en = 0;
      @(negedge clk);
      chk("en_hold_valid", valid, 0);
      chk("en_hold_busy", busy, 0);
      en = 1; ready = 1;
      res("reen_hold", 8, 4, 0);
      repeat (6) @(negedge clk);
      rst = 1;
      repeat (5) @(negedge clk);
      rst = 0;
      skip(1); res("after_rst", 8, 4, 0);
`ifdef CLK_PERIOD_METER_MINMAX_EN
      en = 0; clr = 1; set_div(4, 2);
      repeat (12) @(negedge clk);
      clr = 0; en = 1; skip(2);
      en = 0; set_div(7, 3);
      repeat (12) @(negedge clk);
      en = 1; skip(2);
      chk("minmax_min", pmin, 4);
      chk("minmax_max", pmax, 7);
`endif
      for (int it = 0; it < 150; it++) begin
         int d;
         d = $urandom_range(2, 18);
         if ($urandom_range(0, 7) == 0) gmode = $urandom_range(1, 3);
         else set_div(d, $urandom_range(1, d - 1));
         repeat ($urandom_range(20, 80)) begin
            @(negedge clk);
            ready = $urandom_range(0, 3) != 0;
            en    = $urandom_range(0, 40) != 0;
`ifdef CLK_PERIOD_METER_MINMAX_EN
            clr   = $urandom_range(0, 60) == 0;
`endif
         end
      end
      ready = 1; en = 1;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
